flash_word_packer: RTL and testbench
====================================

Name: flash_word_packer

Overview:
Downstream stage of the HEX ROM loader. Takes the loader's byte-write stream and packs it into 16-bit little-endian program-flash word writes for the Arduboy core's word-addressed program memory. Pairs bytes by address and buffers completed words in a small FIFO. Drains them through a valid/ready port, because the memory write port is shared with the CPU side and may stall.

Parameters:
FIFO_DEPTH, 4, number of word entries in the output FIFO; power of two, at least 2
BYTE_ADDR_WIDTH, 15, width of the incoming byte address; word address width is BYTE_ADDR_WIDTH-1

Ports:
clk_74a  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_wr_en  input  1  one-cycle byte write strobe; no backpressure
in_wr_addr  input  15  byte address
in_wr_data  input  8  byte value
flush  input  1  one-cycle pulse: emit any partially assembled word
out_valid  output  1  FIFO head entry valid
out_ready  input  1  consumer accepts head entry
out_word_addr  output  14  word address of head entry
out_word_data  output  16  head data; bits [7:0] = even byte, bits [15:8] = odd byte
out_byte_en  output  2  head lane enables; bit0 = even byte, bit1 = odd byte
busy  output  1  pending word held or FIFO non-empty
overflow  output  1  sticky: a word was dropped because the FIFO was full
word_count  output  14  number of words accepted into the FIFO; wraps

Behaviour:
- Clock and reset: clk_74a is the clock. reset_n is asynchronous, active-low.
- Reset values: out_valid=0, out_word_addr=0, out_word_data=0, out_byte_en=0, busy=0, overflow=0, word_count=0. Pending register is cleared, FIFO pointers are zeroed, and the deferred-flush flag is cleared. Reset mid-operation discards all pending and buffered data.
- Lane decode: word = in_wr_addr[14:1]; lane = in_wr_addr[0].
- Pending register holds pend_valid, pend_addr[13:0], pend_data[15:0] and pend_be[1:0].
- On in_wr_en, handle exactly one of these cases:
  - A) Nothing pending: load the pending register with this byte. Set pend_be to the lane bit only; the other lane's data is 0.
  - B) Pending, same word, and that lane's pend_be bit is clear: merge the byte in. pend_be becomes 11, the full word is pushed that cycle, and pending is cleared.
  - C) Pending, but a different word or a lane already set: push the existing pending entry (it may be partial). The new byte becomes the pending entry in the same cycle.
- Flush:
  - flush with no in_wr_en: if pending is valid, push it and clear pending; otherwise do nothing.
  - flush coincident with in_wr_en: process the byte write first. The flush is deferred via an internal flag and executed on the next cycle that has no in_wr_en.
- At most one push per cycle, by construction.
- Push rules:
  - A push succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow is set; overflow stays at 1 until reset.
  - word_count increments by 1 on every successful push.
- FIFO is show-ahead:
  - out_valid is 1 whenever the FIFO is non-empty.
  - out_* reflect the head entry, are registered, and hold stable while out_valid=1 and out_ready=0.
  - Pop happens when out_valid && out_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Latency: a push in cycle N makes out_valid=1 in cycle N+1 when the FIFO was empty.
- Pointers use a log2(FIFO_DEPTH)+1-bit wrap scheme. Full and empty are derived from the pointers.
- busy = pend_valid | deferred flush flag | FIFO non-empty.
- The loader's upstream rate is at most 1 byte per 2 cycles. The design must nevertheless accept in_wr_en on consecutive cycles.

Test Plan:
- Even/odd pair: write byte 0x0C at addr 0x0000, then 0x94 at 0x0001, out_ready=1 → the cycle after the second write, out_valid=1, out_word_addr=0x0000, out_word_data=0x940C, out_byte_en=11, word_count=1.
- Odd byte first: write 0xAB at 0x0003, then 0xCD at 0x0002 → one entry: addr 0x0001, data 0xABCD, be=11.
- Discontinuity and flush:
  - Step 1: write 0x11 at 0x0010, then 0x22 at 0x0020 → entry addr 0x0008, data 0x0011, be=01.
  - Step 2: pulse flush → entry addr 0x0010, data 0x0022, be=01; busy drops to 0 once the FIFO is drained.
- Repeated lane: write 0x55 at 0x0004, then 0x66 at 0x0004 → entry addr 0x0002, data 0x0055, be=01; 0x66 stays pending (busy=1).
- Backpressure and overflow (FIFO_DEPTH=4):
  - Hold out_ready=0 and complete 5 word pairs at addrs 0x00..0x09 → overflow=1, word_count=4.
  - Head stays addr 0x0000 with stable data.
  - Release out_ready → 4 entries drain in order (word addrs 0,1,2,3), one per cycle.
- Full with simultaneous pop, then reset:
  - With the FIFO full, hold out_ready=1 and complete a pair in the same cycle → no overflow; the new word appears after the existing 3.
  - Assert reset_n=0 mid-stream → out_valid=0, busy=0, overflow=0 immediately (asynchronously).

Source files
------------

// File: rtl/flash_word_packer_if.sv
// Byte-write stream in, packed word-write stream out, for flash_word_packer.
// The packer takes the master modport; the loader/memory side takes the slave modport.
`timescale 1ns/1ps
interface flash_word_packer_if #(
   parameter int unsigned BYTE_ADDR_WIDTH = 15
);
   logic                       in_wr_en;
   logic [BYTE_ADDR_WIDTH-1:0] in_wr_addr;
   logic [7:0]                 in_wr_data;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic [BYTE_ADDR_WIDTH-2:0] out_word_addr;
   logic [15:0]                out_word_data;
   logic [1:0]                 out_byte_en;

   modport master (
      input  in_wr_en,
      input  in_wr_addr,
      input  in_wr_data,
      input  flush,
      input  out_ready,
      output out_valid,
      output out_word_addr,
      output out_word_data,
      output out_byte_en
   );

   modport slave (
      output in_wr_en,
      output in_wr_addr,
      output in_wr_data,
      output flush,
      output out_ready,
      input  out_valid,
      input  out_word_addr,
      input  out_word_data,
      input  out_byte_en
   );
endinterface

// File: rtl/flash_word_packer.sv
// Packs the loader's byte writes into 16-bit little-endian word writes and
// buffers them in a show-ahead FIFO drained through a valid/ready port.
`timescale 1ns/1ps
module flash_word_packer #(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned BYTE_ADDR_WIDTH = 15
) (
   input  logic                       clk_74a,
   input  logic                       reset_n,
   flash_word_packer_if.master        bus,
   output logic                       busy,
   output logic                       overflow,
   output logic [BYTE_ADDR_WIDTH-2:0] word_count
);
   localparam int unsigned WordAw = BYTE_ADDR_WIDTH - 1;
   localparam int unsigned IdxW   = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW   = IdxW + 1;

   typedef struct packed {
      logic [WordAw-1:0] addr;
      logic [15:0]       data;
      logic [1:0]        be;
   } entry_t;

   // Pending (partially assembled) word and deferred flush
   logic   r_pend_valid;
   entry_t r_pend;
   logic   r_defer;

   logic   w_pend_valid_d;
   entry_t w_pend_d;
   logic   w_defer_d;

   // FIFO storage and wrap-bit pointers
   entry_t            r_mem [FIFO_DEPTH];
   logic [PtrW-1:0]   r_wr_ptr;
   logic [PtrW-1:0]   r_rd_ptr;
   logic              r_overflow;
   logic [WordAw-1:0] r_word_count;

   logic [WordAw-1:0] w_word;
   logic              w_lane;
   logic              w_same_word;
   entry_t            w_new_entry;
   entry_t            w_merged;
   entry_t            w_push_entry;
   entry_t            w_head;
   logic              w_push;
   logic              w_push_ok;
   logic              w_drop;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;

   assign w_word      = bus.in_wr_addr[BYTE_ADDR_WIDTH-1:1];
   assign w_lane      = bus.in_wr_addr[0];
   assign w_same_word = (r_pend.addr == w_word);

   always_comb begin
      w_new_entry      = '0;
      w_new_entry.addr = w_word;
      if (w_lane) begin
         w_new_entry.data = {bus.in_wr_data, 8'h00};
         w_new_entry.be   = 2'b10;
      end else begin
         w_new_entry.data = {8'h00, bus.in_wr_data};
         w_new_entry.be   = 2'b01;
      end
   end

   always_comb begin
      w_merged      = r_pend;
      w_merged.be   = 2'b11;
      if (w_lane) begin
         w_merged.data = {bus.in_wr_data, r_pend.data[7:0]};
      end else begin
         w_merged.data = {r_pend.data[15:8], bus.in_wr_data};
      end
   end

   // Byte writes take priority; a flush that collides with one waits in r_defer
   always_comb begin
      w_pend_valid_d = r_pend_valid;
      w_pend_d       = r_pend;
      w_defer_d      = r_defer;
      w_push         = 1'b0;
      w_push_entry   = r_pend;
      if (bus.in_wr_en) begin
         if (bus.flush) begin
            w_defer_d = 1'b1;
         end
         if (!r_pend_valid) begin
            w_pend_valid_d = 1'b1;
            w_pend_d       = w_new_entry;
         end else if (w_same_word && !r_pend.be[w_lane]) begin
            w_push         = 1'b1;
            w_push_entry   = w_merged;
            w_pend_valid_d = 1'b0;
         end else begin
            w_push       = 1'b1;
            w_push_entry = r_pend;
            w_pend_d     = w_new_entry;
         end
      end else if (bus.flush || r_defer) begin
         w_defer_d = 1'b0;
         if (r_pend_valid) begin
            w_push         = 1'b1;
            w_pend_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_valid <= 1'b0;
         r_pend       <= '0;
         r_defer      <= 1'b0;
      end else begin
         r_pend_valid <= w_pend_valid_d;
         r_pend       <= w_pend_d;
         r_defer      <= w_defer_d;
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[IdxW] != r_rd_ptr[IdxW]) &&
                    (r_wr_ptr[IdxW-1:0] == r_rd_ptr[IdxW-1:0]);
   assign w_pop     = !w_empty && bus.out_ready;
   // When full, a same-cycle pop frees the slot being written
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_ok) begin
         r_mem[r_wr_ptr[IdxW-1:0]] <= w_push_entry;
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_overflow   <= 1'b0;
         r_word_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr     <= r_wr_ptr + PtrW'(1);
            r_word_count <= r_word_count + WordAw'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_head            = r_mem[r_rd_ptr[IdxW-1:0]];
   assign bus.out_valid     = !w_empty;
   assign bus.out_word_addr = w_head.addr;
   assign bus.out_word_data = w_head.data;
   assign bus.out_byte_en   = w_head.be;

   assign busy       = r_pend_valid | r_defer | !w_empty;
   assign overflow   = r_overflow;
   assign word_count = r_word_count;
endmodule

// File: tb/tb_flash_word_packer.sv
// Self-checking bench for flash_word_packer: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_flash_word_packer;
   localparam int unsigned DEPTH = 4;

   logic        clk_74a = 1'b0;
   logic        reset_n = 1'b0;
   logic        busy;
   logic        overflow;
   logic [13:0] word_count;

   int checks = 0;
   int errors = 0;

   flash_word_packer_if #(.BYTE_ADDR_WIDTH(15)) bus ();

   flash_word_packer #(
      .FIFO_DEPTH      (DEPTH),
      .BYTE_ADDR_WIDTH (15)
   ) dut (
      .clk_74a    (clk_74a),
      .reset_n    (reset_n),
      .bus        (bus),
      .busy       (busy),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk_74a = ~clk_74a;

   // Reference model: pending bytes by lane plus a bounded queue of words
   typedef struct packed {
      logic [13:0] a;
      logic [15:0] d;
      logic [1:0]  be;
   } ment_t;

   ment_t    mq[$];
   bit       m_pv;
   int       m_pw;
   bit [7:0] m_pb[2];
   bit [1:0] m_pbe;
   bit       m_def;
   bit       m_ovf;
   int       m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pv = 0; m_pw = 0; m_pb[0] = 0; m_pb[1] = 0; m_pbe = 0;
      m_def = 0; m_ovf = 0; m_cnt = 0;
   endtask

   function automatic ment_t pend_entry();
      ment_t e;
      e.a  = 14'(m_pw);
      e.d  = {m_pb[1], m_pb[0]};
      e.be = m_pbe;
      return e;
   endfunction

   task automatic model_edge(input logic en, input logic [14:0] addr, input logic [7:0] d,
                             input logic fl, input logic rdy);
      ment_t e;
      bit    do_push = 0;
      int    w  = int'(addr >> 1);
      int    ln = int'(addr[0]);
      e = '0;
      if (en) begin
         if (fl) m_def = 1;
         if (m_pv && w == m_pw && !m_pbe[ln]) begin
            m_pb[ln] = d;
            m_pbe    = 2'b11;
            e        = pend_entry();
            do_push  = 1;
            m_pv     = 0;
         end else begin
            if (m_pv) begin
               e       = pend_entry();
               do_push = 1;
            end
            m_pv = 1; m_pw = w; m_pb[0] = 0; m_pb[1] = 0; m_pb[ln] = d;
            m_pbe = 0; m_pbe[ln] = 1'b1;
         end
      end else if (fl || m_def) begin
         m_def = 0;
         if (m_pv) begin
            e       = pend_entry();
            do_push = 1;
            m_pv    = 0;
         end
      end
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (do_push) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(e);
            m_cnt++;
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic compare_model();
      chk("valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("addr", 32'(bus.out_word_addr), 32'(mq[0].a));
         chk("data", 32'(bus.out_word_data), 32'(mq[0].d));
         chk("be", 32'(bus.out_byte_en), 32'(mq[0].be));
      end
      chk("busy", 32'(busy), 32'(m_pv || m_def || mq.size() > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("word_count", 32'(word_count), 32'(14'(m_cnt)));
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge
   task automatic cyc(input logic en, input logic [14:0] addr, input logic [7:0] d,
                      input logic fl, input logic rdy);
      bus.in_wr_en   = en;
      bus.in_wr_addr = addr;
      bus.in_wr_data = d;
      bus.flush      = fl;
      bus.out_ready  = rdy;
      @(posedge clk_74a);
      model_edge(en, addr, d, fl, rdy);
      @(negedge clk_74a);
      compare_model();
   endtask

   task automatic do_reset();
      @(negedge clk_74a);
      reset_n = 1'b0;
      model_reset();
      bus.in_wr_en = 0; bus.flush = 0; bus.out_ready = 0;
      @(negedge clk_74a);
      reset_n = 1'b1;
   endtask

   task automatic chk_head(input string name, input logic [13:0] a, input logic [15:0] d);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_addr"}, 32'(bus.out_word_addr), 32'(a));
      chk({name, "_data"}, 32'(bus.out_word_data), 32'(d));
   endtask

   typedef struct {
      logic        en;
      logic [14:0] addr;
      logic [7:0]  data;
      logic        fl;
      logic        rdy;
      logic        ev;
      logic [13:0] ea;
      logic [15:0] ed;
      logic [1:0]  eb;
      logic        ebusy;
      logic [13:0] ecnt;
   } vec_t;

   vec_t vt[16];

   initial begin
      vt[0]  = '{1, 15'h0000, 8'h0C, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 1, 14'd0};
      vt[1]  = '{1, 15'h0001, 8'h94, 0, 1, 1, 14'h0000, 16'h940C, 2'b11, 1, 14'd1};
      vt[2]  = '{0, 15'h0000, 8'h00, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 0, 14'd1};
      vt[3]  = '{1, 15'h0003, 8'hAB, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 1, 14'd1};
      vt[4]  = '{1, 15'h0002, 8'hCD, 0, 1, 1, 14'h0001, 16'hABCD, 2'b11, 1, 14'd2};
      vt[5]  = '{0, 15'h0000, 8'h00, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 0, 14'd2};
      vt[6]  = '{1, 15'h0010, 8'h11, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 1, 14'd2};
      vt[7]  = '{1, 15'h0020, 8'h22, 0, 1, 1, 14'h0008, 16'h0011, 2'b01, 1, 14'd3};
      vt[8]  = '{0, 15'h0000, 8'h00, 1, 1, 1, 14'h0010, 16'h0022, 2'b01, 1, 14'd4};
      vt[9]  = '{0, 15'h0000, 8'h00, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 0, 14'd4};
      vt[10] = '{1, 15'h0004, 8'h55, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 1, 14'd4};
      vt[11] = '{1, 15'h0004, 8'h66, 0, 1, 1, 14'h0002, 16'h0055, 2'b01, 1, 14'd5};
      vt[12] = '{0, 15'h0000, 8'h00, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 1, 14'd5};
      vt[13] = '{1, 15'h0006, 8'h77, 1, 1, 1, 14'h0002, 16'h0066, 2'b01, 1, 14'd6};
      vt[14] = '{0, 15'h0000, 8'h00, 0, 1, 1, 14'h0003, 16'h0077, 2'b01, 1, 14'd7};
      vt[15] = '{0, 15'h0000, 8'h00, 0, 1, 0, 14'h0000, 16'h0000, 2'b00, 0, 14'd7};

      bus.in_wr_en = 0; bus.in_wr_addr = '0; bus.in_wr_data = '0;
      bus.flush = 0; bus.out_ready = 0;
      model_reset();
      repeat (2) @(negedge clk_74a);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_addr", 32'(bus.out_word_addr), 32'd0);
      chk("rst_data", 32'(bus.out_word_data), 32'd0);
      chk("rst_be", 32'(bus.out_byte_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      reset_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         cyc(vt[i].en, vt[i].addr, vt[i].data, vt[i].fl, vt[i].rdy);
         chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
         if (vt[i].ev) begin
            chk($sformatf("tbl%0d_addr", i), 32'(bus.out_word_addr), 32'(vt[i].ea));
            chk($sformatf("tbl%0d_data", i), 32'(bus.out_word_data), 32'(vt[i].ed));
            chk($sformatf("tbl%0d_be", i), 32'(bus.out_byte_en), 32'(vt[i].eb));
         end
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].ebusy));
         chk($sformatf("tbl%0d_count", i), 32'(word_count), 32'(vt[i].ecnt));
      end

      // Backpressure: five pairs into a four-deep FIFO, back-to-back writes
      for (int i = 0; i < 10; i++) cyc(1, 15'(i), 8'(8'hA0 + i), 0, 0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(word_count), 32'd11);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 15'h0, 8'h0, 0, 0);
         chk_head("ovf_hold", 14'h0000, 16'hA1A0);
      end
      for (int k = 0; k < 4; k++) begin
         chk_head($sformatf("ovf_drain%0d", k), 14'(k), {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)});
         cyc(0, 15'h0, 8'h0, 0, 1);
      end
      chk("ovf_empty", 32'(bus.out_valid), 32'd0);

      // Full FIFO with a same-cycle pop accepts the new word
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 15'(8'h40 + i), 8'(i), 0, 0);
      cyc(1, 15'h0048, 8'h5A, 0, 0);
      cyc(1, 15'h0049, 8'hA5, 0, 1);
      chk("fullpop_ovf", 32'(overflow), 32'd0);
      chk("fullpop_count", 32'(word_count), 32'd5);
      chk_head("fullpop_h0", 14'h0021, 16'h0302);
      cyc(0, 15'h0, 8'h0, 0, 1);
      chk_head("fullpop_h1", 14'h0022, 16'h0504);
      cyc(0, 15'h0, 8'h0, 0, 1);
      chk_head("fullpop_h2", 14'h0023, 16'h0706);
      cyc(0, 15'h0, 8'h0, 0, 1);
      chk_head("fullpop_h3", 14'h0024, 16'hA55A);
      cyc(0, 15'h0, 8'h0, 0, 1);
      chk("fullpop_empty", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset mid-stream with overflow set
      for (int i = 0; i < 11; i++) cyc(1, 15'(i), 8'(i), 0, 0);
      chk("pre_rst_ovf", 32'(overflow), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_overflow", 32'(overflow), 32'd0);
      chk("arst_count", 32'(word_count), 32'd0);
      model_reset();
      bus.in_wr_en = 0; bus.flush = 0;
      @(negedge clk_74a);
      reset_n = 1'b1;

      // Random traffic, mostly-ready consumer
      for (int i = 0; i < 1500; i++) begin
         cyc(1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
      end
      // Random traffic, slow consumer (overflow likely)
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cyc(1'($urandom_range(0, 1)), 15'($urandom_range(0, 31)), 8'($urandom),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
